// File: rtl/bmf_h_decode_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bmf_pkg
// Brief    : Shared BMF defaults, H row packing, popcount and saturating add.
// Revision : 1.0
// ============================================================================
package bmf_pkg;

  localparam int K_DEF = 3;
  localparam int M_DEF = 4;
  localparam int POP_W = 32;

  // Rows are packed low-first: row i lives at bits [i*M +: M].
  function automatic logic [K_DEF*M_DEF-1:0] h_pack(input logic [M_DEF-1:0] r0,
                                                    input logic [M_DEF-1:0] r1,
                                                    input logic [M_DEF-1:0] r2);
    return {r2, r1, r0};
  endfunction

  localparam logic [K_DEF*M_DEF-1:0] H_INIT_DEF = h_pack(4'b0011, 4'b0100, 4'b1000);

  function automatic logic [5:0] popcount(input logic [POP_W-1:0] v);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < POP_W; i++) n = n + 6'(v[i]);
    return n;
  endfunction

  // Clamps a + b at the all-ones value of a w-bit counter.
  function automatic logic [63:0] sat_add(input logic [63:0] a,
                                          input logic [63:0] b,
                                          input int unsigned w);
    logic [63:0] lim;
    logic [64:0] s;
    lim = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    s   = {1'b0, a} + {1'b0, b};
    if (s[64] || (s[63:0] > lim)) return lim;
    return s[63:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/bmf_h_decode_pipe_comb.sv
`default_nettype none
// ============================================================================
// Module   : bmf_h_decode_comb
// Brief    : Combinational OR-AND product po = k (x) H over the Boolean semiring.
// Revision : 1.0
// ============================================================================
module bmf_h_decode_comb
  import bmf_pkg::*;
#(
  parameter int K = K_DEF,
  parameter int M = M_DEF
) (
  input  logic [K-1:0]   k_i,
  input  logic [K*M-1:0] h_i,
  output logic [M-1:0]   po_o
);

  always_comb begin
    po_o = '0;
    for (int j = 0; j < M; j++) begin
      for (int i = 0; i < K; i++) begin
        po_o[j] = po_o[j] | (k_i[i] & h_i[i*M + j]);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/bmf_h_decode_pipe.sv
`default_nettype none
// ============================================================================
// Module   : bmf_h_decode_pipe
// Brief    : Two-stage valid/ready H-decode pipe with error statistics.
// Revision : 1.0
// ============================================================================
module bmf_h_decode_pipe
  import bmf_pkg::*;
#(
  parameter int             K      = K_DEF,
  parameter int             M      = M_DEF,
  parameter logic [K*M-1:0] H_INIT = H_INIT_DEF,
  parameter int             CW     = 32
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [K-1:0]                         in_k,
  input  logic [M-1:0]                         in_exact,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [M-1:0]                         out_po,
  output logic                                 out_err,
  input  logic                                 cfg_we,
  input  logic [((K > 1) ? $clog2(K) : 1)-1:0] cfg_row,
  input  logic [M-1:0]                         cfg_data,
  output logic                                 cfg_rej,
  input  logic                                 cnt_clr,
  output logic [CW-1:0]                        sample_cnt,
  output logic [CW-1:0]                        err_cnt,
  output logic [CW-1:0]                        hd_sum
);

  localparam int HDW = $clog2(M + 1);

  logic           s1_valid_q, s1_valid_d;
  logic [K-1:0]   s1_k_q, s1_k_d;
  logic [M-1:0]   s1_exact_q, s1_exact_d;
  logic           s2_valid_q, s2_valid_d;
  logic [M-1:0]   s2_po_q, s2_po_d;
  logic [M-1:0]   s2_exact_q, s2_exact_d;
  logic [HDW-1:0] s2_hd_q, s2_hd_d;
  logic [K*M-1:0] h_q, h_d;
  logic           cfg_rej_q, cfg_rej_d;
  logic [CW-1:0]  sample_q, sample_d;
  logic [CW-1:0]  err_q, err_d;
  logic [CW-1:0]  hd_q, hd_d;

  logic           s1_adv;
  logic           s2_adv;
  logic           fire;
  logic           row_ok;
  logic           cfg_ok;
  logic [M-1:0]   s1_po;

  bmf_h_decode_comb #(
    .K (K),
    .M (M)
  ) u_decode (
    .k_i  (s1_k_q),
    .h_i  (h_q),
    .po_o (s1_po)
  );

  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;
  assign fire     = s2_valid_q && out_ready;

  assign out_valid  = s2_valid_q;
  assign out_po     = s2_po_q;
  assign out_err    = (s2_po_q != s2_exact_q);
  assign cfg_rej    = cfg_rej_q;
  assign sample_cnt = sample_q;
  assign err_cnt    = err_q;
  assign hd_sum     = hd_q;

  // H may only change when nothing is in flight or about to enter.
  assign row_ok = (32'(cfg_row) < K);
  assign cfg_ok = cfg_we && row_ok && !s1_valid_q && !s2_valid_q && !in_valid;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_k_d     = s1_k_q;
    s1_exact_d = s1_exact_q;
    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_k_d     = in_k;
        s1_exact_d = in_exact;
      end
    end
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_po_d    = s2_po_q;
    s2_exact_d = s2_exact_q;
    s2_hd_d    = s2_hd_q;
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_po_d    = s1_po;
        s2_exact_d = s1_exact_q;
        s2_hd_d    = HDW'(popcount(POP_W'(s1_po ^ s1_exact_q)));
      end
    end
  end

  always_comb begin
    h_d       = h_q;
    cfg_rej_d = cfg_we && !cfg_ok;
    for (int i = 0; i < K; i++) begin
      if (cfg_ok && (32'(cfg_row) == i)) h_d[i*M +: M] = cfg_data;
    end
  end

  // Clear wins over a coincident handshake; that beat still leaves the pipe.
  always_comb begin
    sample_d = sample_q;
    err_d    = err_q;
    hd_d     = hd_q;
    if (cnt_clr) begin
      sample_d = '0;
      err_d    = '0;
      hd_d     = '0;
    end else if (fire) begin
      sample_d = CW'(sat_add(64'(sample_q), 64'd1, CW));
      err_d    = CW'(sat_add(64'(err_q), 64'(out_err), CW));
      hd_d     = CW'(sat_add(64'(hd_q), 64'(s2_hd_q), CW));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_k_q     <= '0;
      s1_exact_q <= '0;
      s2_valid_q <= 1'b0;
      s2_po_q    <= '0;
      s2_exact_q <= '0;
      s2_hd_q    <= '0;
      h_q        <= H_INIT;
      cfg_rej_q  <= 1'b0;
      sample_q   <= '0;
      err_q      <= '0;
      hd_q       <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_k_q     <= s1_k_d;
      s1_exact_q <= s1_exact_d;
      s2_valid_q <= s2_valid_d;
      s2_po_q    <= s2_po_d;
      s2_exact_q <= s2_exact_d;
      s2_hd_q    <= s2_hd_d;
      h_q        <= h_d;
      cfg_rej_q  <= cfg_rej_d;
      sample_q   <= sample_d;
      err_q      <= err_d;
      hd_q       <= hd_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bmf_h_decode_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_bmf_h_decode_pipe
// Brief    : Directed self-checking bench; a CW=4 twin exercises saturation.
// Revision : 1.0
// ============================================================================
module tb_bmf_h_decode_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [2:0] in_k;
  logic [3:0] in_exact;
  logic       out_ready;
  logic       cfg_we;
  logic [1:0] cfg_row;
  logic [3:0] cfg_data;
  logic       cnt_clr;

  logic        in_ready, out_valid, out_err, cfg_rej;
  logic [3:0]  out_po;
  logic [31:0] sample_cnt, err_cnt, hd_sum;

  logic        in_ready4, out_valid4, out_err4, cfg_rej4;
  logic [3:0]  out_po4;
  logic [3:0]  sample_cnt4, err_cnt4, hd_sum4;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  bmf_h_decode_pipe #(.CW(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_k(in_k), .in_exact(in_exact), .out_valid(out_valid), .out_ready(out_ready),
    .out_po(out_po), .out_err(out_err), .cfg_we(cfg_we), .cfg_row(cfg_row),
    .cfg_data(cfg_data), .cfg_rej(cfg_rej), .cnt_clr(cnt_clr),
    .sample_cnt(sample_cnt), .err_cnt(err_cnt), .hd_sum(hd_sum)
  );

  bmf_h_decode_pipe #(.CW(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
    .in_k(in_k), .in_exact(in_exact), .out_valid(out_valid4), .out_ready(out_ready),
    .out_po(out_po4), .out_err(out_err4), .cfg_we(cfg_we), .cfg_row(cfg_row),
    .cfg_data(cfg_data), .cfg_rej(cfg_rej4), .cnt_clr(cnt_clr),
    .sample_cnt(sample_cnt4), .err_cnt(err_cnt4), .hd_sum(hd_sum4)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] exp8 [8];

  initial begin
    exp8 = '{4'b0000, 4'b0011, 4'b0100, 4'b0111, 4'b1000, 4'b1011, 4'b1100, 4'b1111};
    rst = 1'b1; in_valid = 1'b0; in_k = '0; in_exact = '0; out_ready = 1'b1;
    cfg_we = 1'b0; cfg_row = '0; cfg_data = '0; cnt_clr = 1'b0;
    repeat (2) step();
    rst = 1'b0;
    #1;

    // reset state
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_po", out_po, 0);
    check_eq("rst_err", out_err, 0);
    check_eq("rst_sample", sample_cnt, 0);
    check_eq("rst_errcnt", err_cnt, 0);
    check_eq("rst_hd", hd_sum, 0);
    check_eq("rst_cfgrej", cfg_rej, 0);
    check_eq("rst_inready", in_ready, 1);

    // single beat, latency 2
    in_valid = 1'b1; in_k = 3'b001; in_exact = 4'b0011;
    step();
    in_valid = 1'b0;
    check_eq("t1_lat1_valid", out_valid, 0);
    step();
    check_eq("t1_valid", out_valid, 1);
    check_eq("t1_po", out_po, 4'b0011);
    check_eq("t1_err", out_err, 0);
    step();
    check_eq("t1_sample", sample_cnt, 1);
    check_eq("t1_errcnt", err_cnt, 0);
    check_eq("t1_drained", out_valid, 0);

    // all eight k values back-to-back
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    check_eq("clr_sample", sample_cnt, 0);
    for (int c = 0; c <= 8; c++) begin
      if (c < 8) begin
        in_valid = 1'b1; in_k = 3'(c); in_exact = 4'hF;
      end else begin
        in_valid = 1'b0;
      end
      step();
      if (c >= 1) begin
        check_eq($sformatf("t2_valid%0d", c - 1), out_valid, 1);
        check_eq($sformatf("t2_po%0d", c - 1), out_po, exp8[c-1]);
      end
    end
    step();
    check_eq("t2_drained", out_valid, 0);
    check_eq("t2_sample", sample_cnt, 8);
    check_eq("t2_errcnt", err_cnt, 7);
    check_eq("t2_hd", hd_sum, 16);
    check_eq("t2_hd_sat4", hd_sum4, 15);

    // back-pressure: 3 beats offered, out_ready low for 5 edges
    out_ready = 1'b0; in_valid = 1'b1; in_k = 3'b001; in_exact = 4'b0000;
    step();
    check_eq("t3_ready_after1", in_ready, 1);
    in_k = 3'b010;
    step();
    in_k = 3'b100;
    check_eq("t3_ready_after2", in_ready, 0);
    check_eq("t3_valid", out_valid, 1);
    check_eq("t3_po_stall", out_po, 4'b0011);
    for (int s = 0; s < 3; s++) begin
      step();
      check_eq($sformatf("t3_po_hold%0d", s), out_po, 4'b0011);
      check_eq($sformatf("t3_ready_hold%0d", s), in_ready, 0);
    end
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check_eq("t3_po_b", out_po, 4'b0100);
    step();
    check_eq("t3_po_c", out_po, 4'b1000);
    step();
    check_eq("t3_drained", out_valid, 0);
    check_eq("t3_sample", sample_cnt, 11);
    check_eq("t3_errcnt", err_cnt, 10);
    check_eq("t3_hd", hd_sum, 20);

    // H row write with empty pipe
    cfg_we = 1'b1; cfg_row = 2'd1; cfg_data = 4'b0001;
    step();
    cfg_we = 1'b0;
    check_eq("t4_accept_norej", cfg_rej, 0);
    in_valid = 1'b1; in_k = 3'b010; in_exact = 4'b0001;
    step();
    in_valid = 1'b0;
    step();
    check_eq("t4_po_newh", out_po, 4'b0001);
    check_eq("t4_err_newh", out_err, 0);
    step();

    // write while a beat is in flight is rejected
    in_valid = 1'b1; in_k = 3'b010; in_exact = 4'b0001;
    step();
    in_valid = 1'b0; cfg_we = 1'b1; cfg_row = 2'd1; cfg_data = 4'b1111;
    step();
    cfg_we = 1'b0;
    check_eq("t4_rej_busy", cfg_rej, 1);
    check_eq("t4_po_inflight", out_po, 4'b0001);
    step();
    check_eq("t4_rej_pulse", cfg_rej, 0);

    // out-of-range row is rejected
    cfg_we = 1'b1; cfg_row = 2'd3; cfg_data = 4'b1111;
    step();
    cfg_we = 1'b0; cfg_row = 2'd1;
    check_eq("t4_rej_row", cfg_rej, 1);
    step();
    check_eq("t4_rej_row_pulse", cfg_rej, 0);
    in_valid = 1'b1; in_k = 3'b010; in_exact = 4'b0001;
    step();
    in_valid = 1'b0;
    step();
    check_eq("t4_h_unchanged", out_po, 4'b0001);
    step();
    check_eq("t4_sample", sample_cnt, 14);

    // saturation on the CW=4 twin
    for (int b = 0; b < 3; b++) begin
      in_valid = 1'b1; in_k = 3'b000; in_exact = 4'b0000;
      step();
    end
    in_valid = 1'b0;
    step();
    step();
    check_eq("t5_sample32", sample_cnt, 17);
    check_eq("t5_sample_sat4", sample_cnt4, 15);

    // clear coincident with a handshake
    in_valid = 1'b1; in_k = 3'b001; in_exact = 4'b0011;
    step();
    in_valid = 1'b0;
    step();
    check_eq("t5_clr_beat_valid", out_valid, 1);
    check_eq("t5_clr_beat_po", out_po, 4'b0011);
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    check_eq("t5_clr_sample", sample_cnt, 0);
    check_eq("t5_clr_sample4", sample_cnt4, 0);
    check_eq("t5_clr_errcnt", err_cnt, 0);
    check_eq("t5_clr_hd", hd_sum, 0);
    check_eq("t5_clr_delivered", out_valid, 0);

    // reset with two beats in flight
    in_valid = 1'b1; in_k = 3'b001; in_exact = 4'b0000;
    step();
    in_k = 3'b010;
    step();
    in_k = 3'b100;
    step();
    in_valid = 1'b0;
    check_eq("t6_pre_sample", sample_cnt, 1);
    check_eq("t6_pre_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    check_eq("t6_rst_valid", out_valid, 0);
    check_eq("t6_rst_sample", sample_cnt, 0);
    check_eq("t6_rst_errcnt", err_cnt, 0);
    check_eq("t6_rst_hd", hd_sum, 0);
    step();
    step();
    rst = 1'b0;
    for (int s = 0; s < 4; s++) begin
      step();
      check_eq($sformatf("t6_no_stale%0d", s), out_valid, 0);
    end
    in_valid = 1'b1; in_k = 3'b010; in_exact = 4'b0100;
    step();
    in_valid = 1'b0;
    step();
    check_eq("t6_h_init_po", out_po, 4'b0100);
    check_eq("t6_h_init_err", out_err, 0);
    step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
